// File: rtl/or_reduce_serial.sv
// ---------------------------------------------------------------------------
// or_reduce_serial
//   Multi-cycle OR-reduction engine. A WIDTH-bit word is zero-padded up to a
//   whole number of 8-bit chunks. The chunks are then streamed, LSB chunk
//   first and one per clock, through a single 8-input OR stage. The engine
//   reports whether any bit was set (out_any), its complement (out_zero), and
//   the number of chunk cycles used (out_cycles). Both sides use valid/ready
//   handshakes. Only one word is in flight at a time.
//
// Parameters
//   WIDTH  input word width (>= 8)
//   EARLY  1: stop at the first non-zero chunk; 0: always scan every chunk
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   in_data is valid
//   in_ready    out  engine is idle and can accept a word
//   in_data     in   word to reduce (WIDTH bits)
//   out_valid   out  result valid; held until accepted
//   out_ready   in   consumer accepts the result
//   out_any     out  1 if any bit of the word was 1
//   out_zero    out  ~out_any, registered alongside it
//   out_cycles  out  chunk cycles used for this result (8 bits)
// ---------------------------------------------------------------------------
module or_reduce_serial #(
  parameter int WIDTH = 16,
  parameter bit EARLY = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_any,
  output logic             out_zero,
  output logic [7:0]       out_cycles
);

  localparam int NCHUNK = (WIDTH + 7) / 8;
  localparam int WORD_W = NCHUNK * 8;
  localparam int IDX_W  = $clog2(NCHUNK) + 1;
  // Chunk-select width. A single-chunk word still needs a 1-bit select.
  localparam int SEL_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [NCHUNK-1:0][7:0] word_q;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   acc_q, acc_d;
  logic                   any_q, any_d;
  logic                   zero_q, zero_d;
  logic [7:0]             cycles_q, cycles_d;

  logic [SEL_W-1:0]       chunk_sel;
  logic [7:0]             chunk;
  logic                   or8;
  logic                   accept;
  logic                   last_step;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign chunk_sel = idx_q[SEL_W-1:0];
  assign chunk     = word_q[chunk_sel];

  // The single 8-way OR stage that every chunk passes through.
  assign or8 = |chunk;

  assign last_step = (EARLY && or8) || (idx_q == LAST_IDX);

  // Handshake flags are decoded straight from the state register, so a reset
  // drops out_valid and raises in_ready without waiting for a clock edge.
  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_any    = any_q;
  assign out_zero   = zero_q;
  assign out_cycles = cycles_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    any_d    = any_q;
    zero_d   = zero_q;
    cycles_d = cycles_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d   = '0;
          acc_d   = 1'b0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        acc_d = acc_q | or8;
        if (last_step) begin
          // Hold idx on the final chunk so it never passes NCHUNK-1.
          state_d  = S_DONE;
          any_d    = acc_q | or8;
          zero_d   = ~(acc_q | or8);
          cycles_d = 8'(idx_q) + 8'd1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= 1'b0;
      any_q    <= 1'b0;
      zero_q   <= 1'b1;
      cycles_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      any_q    <= any_d;
      zero_q   <= zero_d;
      cycles_q <= cycles_d;
    end
  end

  // NOTE: the word buffer is pure datapath and has no reset. It is only read
  // in SCAN, and SCAN can only be reached through the load below.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= WORD_W'(in_data);
    end
  end

endmodule

// File: tb/tb_or_reduce_serial.sv
// ---------------------------------------------------------------------------
// tb_or_reduce_serial
//   Self-checking bench for or_reduce_serial. It runs three instances on a
//   shared clock and reset:
//     0: WIDTH=16, EARLY=1
//     1: WIDTH=16, EARLY=0
//     2: WIDTH=12, EARLY=1
//   Expected results come from a chunk-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_or_reduce_serial;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      in_valid;
  logic [2:0]      in_ready;
  logic [2:0]      out_valid;
  logic [2:0]      out_ready;
  logic [2:0]      out_any;
  logic [2:0]      out_zero;
  logic [2:0][7:0] out_cycles;
  logic [15:0]     in_data0;
  logic [15:0]     in_data1;
  logic [11:0]     in_data2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  or_reduce_serial #(.WIDTH(16), .EARLY(1'b1)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data0),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_any(out_any[0]), .out_zero(out_zero[0]), .out_cycles(out_cycles[0])
  );

  or_reduce_serial #(.WIDTH(16), .EARLY(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data1),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_any(out_any[1]), .out_zero(out_zero[1]), .out_cycles(out_cycles[1])
  );

  or_reduce_serial #(.WIDTH(12), .EARLY(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data2),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_any(out_any[2]), .out_zero(out_zero[2]), .out_cycles(out_cycles[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model. The word is split into ceil(width/8) byte chunks. With
  // EARLY=1 the cycle count is the position of the first non-zero byte plus
  // one. Otherwise every chunk is scanned.
  function automatic void model(input logic [15:0] data, input int width, input bit early,
                                output logic exp_any, output int exp_cyc);
    int          n;
    logic [15:0] m;
    bit          found;
    n       = (width + 7) / 8;
    m       = data & 16'((32'd1 << width) - 1);
    exp_any = (m != 16'd0);
    exp_cyc = n;
    found   = 1'b0;
    if (early) begin
      for (int i = 0; i < n; i++) begin
        if (!found && (((m >> (8 * i)) & 16'hff) != 16'd0)) begin
          exp_cyc = i + 1;
          found   = 1'b1;
        end
      end
    end
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 2) ? 12 : 16;
  endfunction

  function automatic bit early_of(input int sel);
    return (sel == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic set_data(input int sel, input logic [15:0] data);
    case (sel)
      0:       in_data0 = data;
      1:       in_data1 = data;
      default: in_data2 = data[11:0];
    endcase
  endtask

  // Present a word and complete the handshake on the next rising edge.
  task automatic start_word(input int sel, input logic [15:0] data, input string tag);
    set_data(sel, data);
    in_valid[sel] = 1'b1;
    check({tag, " in_ready idle"}, in_ready[sel], 1);
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    check({tag, " in_ready busy"}, in_ready[sel], 0);
  endtask

  // Count the edges from the accept edge until out_valid rises. The wait is
  // bounded; if the bound runs out, the latency check fails.
  task automatic wait_result(input int sel, input logic exp_any, input int exp_cyc,
                             input string tag);
    int lat;
    lat = 0;
    while (out_valid[sel] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_cyc);
    check({tag, " any"}, out_any[sel], exp_any);
    check({tag, " zero"}, out_zero[sel], !exp_any);
    check({tag, " cycles"}, out_cycles[sel], exp_cyc);
  endtask

  task automatic accept_result(input int sel, input string tag);
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready[sel] = 1'b0;
    check({tag, " valid dropped"}, out_valid[sel], 0);
    check({tag, " back to idle"}, in_ready[sel], 1);
  endtask

  task automatic run_word(input int sel, input logic [15:0] data, input logic exp_any,
                          input int exp_cyc, input string tag);
    start_word(sel, data, tag);
    wait_result(sel, exp_any, exp_cyc, tag);
    accept_result(sel, tag);
  endtask

  initial begin
    logic [15:0] d;
    logic        m_any;
    int          m_cyc;
    int          sel;

    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    in_data0  = '0;
    in_data1  = '0;
    in_data2  = '0;

    // Reset state of every instance.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset in_ready[%0d]", i), in_ready[i], 1);
      check($sformatf("reset out_valid[%0d]", i), out_valid[i], 0);
      check($sformatf("reset any[%0d]", i), out_any[i], 0);
      check($sformatf("reset zero[%0d]", i), out_zero[i], 1);
      check($sformatf("reset cycles[%0d]", i), out_cycles[i], 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    run_word(0, 16'h0000, 1'b0, 2, "w16e1 0000");
    run_word(0, 16'h0001, 1'b1, 1, "w16e1 0001");
    run_word(0, 16'h8000, 1'b1, 2, "w16e1 8000");
    run_word(1, 16'h0001, 1'b1, 2, "w16e0 0001");
    run_word(1, 16'h0000, 1'b0, 2, "w16e0 0000");
    run_word(2, 16'h0800, 1'b1, 2, "w12 800");
    run_word(2, 16'h0001, 1'b1, 1, "w12 001");
    run_word(2, 16'h0000, 1'b0, 2, "w12 000");

    // out_ready while idle is ignored, and the last result is retained.
    out_ready[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle ready valid", out_valid[0], 0);
      check("idle ready any kept", out_any[0], 1);
      check("idle ready cycles kept", out_cycles[0], 2);
    end
    out_ready[0] = 1'b0;

    // Back-pressure: the result is held, and a second word waits.
    start_word(0, 16'h8000, "hold first");
    wait_result(0, 1'b1, 2, "hold first");
    set_data(0, 16'h0001);
    in_valid[0] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold valid", out_valid[0], 1);
      check("hold any", out_any[0], 1);
      check("hold cycles", out_cycles[0], 2);
      check("hold in_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("hold released valid", out_valid[0], 0);
    check("hold released in_ready", in_ready[0], 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("hold second taken", in_ready[0], 0);
    wait_result(0, 1'b1, 1, "hold second");
    accept_result(0, "hold second");

    // Randomized words against the reference model.
    for (int i = 0; i < 36; i++) begin
      sel = i % 3;
      case ($urandom_range(0, 3))
        0:       d = 16'h0000;
        1:       d = {8'($urandom), 8'h00};
        2:       d = 16'h0001 << $urandom_range(0, 15);
        default: d = 16'($urandom);
      endcase
      if (sel == 2) d = d & 16'h0fff;
      model(d, width_of(sel), early_of(sel), m_any, m_cyc);
      run_word(sel, d, m_any, m_cyc, $sformatf("rand%0d s%0d %h", i, sel, d));
    end

    // Reset in the middle of SCAN.
    start_word(0, 16'h0000, "rst scan");
    reset_n = 1'b0;
    #1;
    check("rst scan valid", out_valid[0], 0);
    check("rst scan in_ready", in_ready[0], 1);
    check("rst scan zero", out_zero[0], 1);
    check("rst scan any", out_any[0], 0);
    check("rst scan cycles", out_cycles[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst scan no spurious valid", out_valid[0], 0);
    end

    // Reset in the middle of DONE.
    start_word(0, 16'h0001, "rst done");
    wait_result(0, 1'b1, 1, "rst done");
    reset_n = 1'b0;
    #1;
    check("rst done valid", out_valid[0], 0);
    check("rst done in_ready", in_ready[0], 1);
    check("rst done zero", out_zero[0], 1);
    check("rst done any", out_any[0], 0);
    check("rst done cycles", out_cycles[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_word(0, 16'h0100, 1'b1, 2, "after rst 0100");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
